steed_fifo_seq: RTL and testbench
=================================

// Module: steed_fifo_seq
// PURPOSE
//  Sequences the shared host<->NAND sector FIFO for one ATA data transfer at a time.
//  - Sets FIFO direction, selects writer/reader and gates per-word enables from the
//    IDE-side and NAND-side strobes.
//  - Counts words per sector and sectors per command; raises the ATA DRQ block handshake.
//  - Sits inside steed, between the ATA task-file logic, the NAND engine and fifo.
// PARAMETERS
//  DW            16   FIFO data width; equals `FIFO_DATA_WIDTH
//  SECTOR_WORDS  256  words per sector; each FIFO fill/drain phase is one sector
//  CW            9    word/sector counter width; must satisfy 2**CW > SECTOR_WORDS
// PORTS
//  clk             in   1   system clock (ocs_clk)
//  rst_n           in   1   async active-low reset
//  xfer_start      in   1   pulse: start transfer; honoured only in IDLE
//  xfer_dir        in   1   1 = host->NAND (write cmd), 0 = NAND->host (read cmd); sampled with start
//  xfer_sectors    in   8   sector count; 0 means 256 (ATA)
//  xfer_abort      in   1   pulse: abort current transfer
//  host_wr_strb    in   1   one IDE data word is valid on host_data (DIOW)
//  host_rd_strb    in   1   host consumes one word from FIFO (DIOR)
//  host_data       in   DW  IDE write data
//  nand_wr_strb    in   1   NAND engine presents one word on nand_data
//  nand_rd_strb    in   1   NAND engine consumes one word
//  nand_data       in   DW  NAND read data
//  fifo_full       in   1   from fifo
//  fifo_empty      in   1   from fifo
//  fifo_host_nand  out  1   FIFO direction: 1 = host writes, NAND reads
//  fifo_wr_cs      out  1   FIFO write-side select
//  fifo_rd_cs      out  1   FIFO read-side select
//  fifo_wr_en      out  1   FIFO push
//  fifo_rd_en      out  1   FIFO pop
//  fifo_data_in    out  DW  host_data when fifo_host_nand=1, else nand_data
//  host_drq        out  1   ATA DRQ: host may move the current sector
//  nand_go         out  1   NAND engine may move the current sector
//  xfer_busy       out  1   state != IDLE
//  xfer_done       out  1   1-cycle pulse: all sectors moved
//  xfer_aborted    out  1   1-cycle pulse: flush after abort complete
//  ovf_err         out  1   sticky: strobe dropped (full/empty); cleared by accepted xfer_start
// BEHAVIOUR
//  Reset: state IDLE, counters 0, all outputs 0 (fifo_data_in follows the mux).
//  States: IDLE, H2N_FILL, H2N_DRAIN, N2H_FILL, N2H_DRAIN, DONE, FLUSH.
//  - IDLE: start & dir=1 -> H2N_FILL; start & dir=0 -> N2H_FILL.
//    Load sec_left = (xfer_sectors==0) ? 256 : xfer_sectors; wcnt = 0.
//  - Accepted word = writer strobe & !fifo_full, or reader strobe & !fifo_empty, in the
//    phase that owns that side. Strobes from the non-owning side are ignored, no error.
//  - Enables are combinational from the strobe gated by registered state; zero added latency.
//  - Each accepted word increments wcnt. On the accept with wcnt==SECTOR_WORDS-1:
//    wcnt <= 0 and the phase advances the next cycle.
//  - H2N_FILL -> H2N_DRAIN. H2N_DRAIN -> H2N_FILL, or DONE if sec_left==1;
//    sec_left decrements on the drain-complete word. N2H is symmetric
//    (N2H_FILL -> N2H_DRAIN -> ...).
//  - Outputs in H2N_FILL: host_drq, fifo_host_nand, wr_cs.
//    H2N_DRAIN: nand_go, fifo_host_nand, rd_cs.
//    N2H_FILL: nand_go, wr_cs. N2H_DRAIN: host_drq, rd_cs.
//    All are registered from state and change one cycle after the last accepted word.
//  - DONE: xfer_done = 1 for one cycle, then IDLE.
//  - xfer_abort has priority over start and strobes in every non-IDLE state -> FLUSH
//    (abort in IDLE is ignored).
//  - FLUSH: rd_cs = 1, fifo_rd_en = !fifo_empty, fifo_host_nand holds its last value.
//    When fifo_empty: xfer_aborted pulses once and the block returns to IDLE.
//  - Dropped strobe (writer strobe & full, or reader strobe & empty, in the owning phase)
//    sets ovf_err; wcnt is unchanged.
//  - xfer_start while busy is ignored. xfer_sectors is sampled only on an accepted start.
//  - rst_n low mid-transfer: immediate return to reset values; FIFO contents are cleared by
//    fifo's own reset.
// TESTING
//  - Reset: rst_n low with strobes toggling -> all outputs 0, state IDLE, no fifo_wr_en.
//  - Write, 2 sectors: start dir=1 sectors=2; 256 host_wr_strb.
//    -> host_drq drops the cycle after word 256, nand_go rises.
//    256 nand_rd_strb -> host_drq again; after 2nd drain, xfer_done pulses once.
//  - Read, sectors=0: 256 sectors of N2H fill/drain (65536 words each side)
//    -> exactly one xfer_done; fifo_host_nand = 0 throughout.
//  - Overflow: hold fifo_full=1 during H2N_FILL, 3 host_wr_strb
//    -> no fifo_wr_en, wcnt stays 0, ovf_err = 1 until the next start.
//  - Abort: after 100 host words, pulse xfer_abort with fifo_empty low for 100 cycles
//    -> FLUSH, rd_en for 100 cycles, then xfer_aborted pulse and IDLE.
//  - Collision: xfer_start and xfer_abort in the same cycle mid-N2H_DRAIN
//    -> abort wins, start ignored, sec_left unchanged until FLUSH ends.

Source files
------------

// File: rtl/steed_fifo_seq.sv
// steed_fifo_seq -- sequencer for the shared host<->NAND sector FIFO.
//
// Runs one ATA data transfer at a time. Each sector is first filled into the FIFO
// by the writer side, then drained from it by the reader side. H2N: host fills
// and NAND drains. N2H: NAND fills and host drains. The block counts words per
// sector and sectors per command. It drives the ATA DRQ and NAND go handshakes.
// On abort it drains the FIFO before it returns to idle.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   xfer_start/dir/sectors     command launch; sampled only when IDLE (sectors 0 = 256)
//   xfer_abort                 abort the running transfer; flushes the FIFO
//   host_wr/rd_strb, host_data IDE side word strobes and write data
//   nand_wr/rd_strb, nand_data NAND engine word strobes and read data
//   fifo_full, fifo_empty      FIFO status
//   fifo_*                     FIFO direction, selects, push/pop and write data
//   host_drq, nand_go          per-sector handshakes
//   xfer_busy/done/aborted     transfer status; done/aborted are 1-cycle pulses
//   ovf_err                    sticky dropped-strobe flag, cleared by an accepted start
module steed_fifo_seq #(
    parameter int DW           = 16,
    parameter int SECTOR_WORDS = 256,
    parameter int CW           = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          xfer_start,
    input  logic          xfer_dir,
    input  logic [7:0]    xfer_sectors,
    input  logic          xfer_abort,
    input  logic          host_wr_strb,
    input  logic          host_rd_strb,
    input  logic [DW-1:0] host_data,
    input  logic          nand_wr_strb,
    input  logic          nand_rd_strb,
    input  logic [DW-1:0] nand_data,
    input  logic          fifo_full,
    input  logic          fifo_empty,
    output logic          fifo_host_nand,
    output logic          fifo_wr_cs,
    output logic          fifo_rd_cs,
    output logic          fifo_wr_en,
    output logic          fifo_rd_en,
    output logic [DW-1:0] fifo_data_in,
    output logic          host_drq,
    output logic          nand_go,
    output logic          xfer_busy,
    output logic          xfer_done,
    output logic          xfer_aborted,
    output logic          ovf_err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_H2N_FILL  = 3'd1;
    localparam logic [2:0] S_H2N_DRAIN = 3'd2;
    localparam logic [2:0] S_N2H_FILL  = 3'd3;
    localparam logic [2:0] S_N2H_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;
    localparam logic [2:0] S_FLUSH     = 3'd6;

    localparam logic [CW-1:0] LAST_WORD = CW'(SECTOR_WORDS - 1);

    logic [2:0]    state;
    logic [CW-1:0] wcnt;
    logic [8:0]    sec_left;   // 9 bits so that 256 sectors can be held
    logic          dir_q;      // direction of the current or last transfer, shown during FLUSH
    logic          aborted_q;
    logic          ovf_q;

    logic wr_phase, rd_phase, wr_strb, rd_strb, live;
    logic wr_acc, rd_acc, acc, drop, last_word, in_flush;

    // Phase decode. Only the side that owns the current phase can move words.
    // Strobes from the other side are ignored.
    assign wr_phase = (state == S_H2N_FILL)  || (state == S_N2H_FILL);
    assign rd_phase = (state == S_H2N_DRAIN) || (state == S_N2H_DRAIN);
    assign in_flush = (state == S_FLUSH);

    always_comb begin
        wr_strb = 1'b0;
        rd_strb = 1'b0;
        case (state)
            S_H2N_FILL:  wr_strb = host_wr_strb;
            S_N2H_FILL:  wr_strb = nand_wr_strb;
            S_H2N_DRAIN: rd_strb = nand_rd_strb;
            S_N2H_DRAIN: rd_strb = host_rd_strb;
            default: ;
        endcase
    end

    // Abort outranks any strobe in the same cycle. Gating here keeps the count,
    // the enables and the error flag consistent with the FLUSH entry.
    assign live      = !xfer_abort;
    assign wr_acc    = live && wr_phase && wr_strb && !fifo_full;
    assign rd_acc    = live && rd_phase && rd_strb && !fifo_empty;
    assign acc       = wr_acc || rd_acc;
    assign drop      = live && ((wr_phase && wr_strb && fifo_full) ||
                                (rd_phase && rd_strb && fifo_empty));
    assign last_word = acc && (wcnt == LAST_WORD);

    assign fifo_wr_en     = wr_acc;
    assign fifo_rd_en     = rd_acc || (in_flush && !fifo_empty);
    assign fifo_wr_cs     = wr_phase;
    assign fifo_rd_cs     = rd_phase || in_flush;
    assign host_drq       = (state == S_H2N_FILL) || (state == S_N2H_DRAIN);
    assign nand_go        = (state == S_H2N_DRAIN) || (state == S_N2H_FILL);
    assign fifo_host_nand = (state == S_H2N_FILL) || (state == S_H2N_DRAIN) ||
                            (in_flush && dir_q);
    assign fifo_data_in   = fifo_host_nand ? host_data : nand_data;
    assign xfer_busy      = (state != S_IDLE);
    assign xfer_done      = (state == S_DONE);
    assign xfer_aborted   = aborted_q;
    assign ovf_err        = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wcnt      <= '0;
            sec_left  <= '0;
            dir_q     <= 1'b0;
            aborted_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            aborted_q <= 1'b0;
            if (state == S_IDLE) begin
                if (xfer_start) begin
                    state    <= xfer_dir ? S_H2N_FILL : S_N2H_FILL;
                    dir_q    <= xfer_dir;
                    sec_left <= (xfer_sectors == 8'd0) ? 9'd256 : {1'b0, xfer_sectors};
                    wcnt     <= '0;
                    ovf_q    <= 1'b0;
                end
            end else if (xfer_abort) begin
                state <= S_FLUSH;
            end else begin
                case (state)
                    S_H2N_FILL, S_N2H_FILL: begin
                        if (last_word) begin
                            wcnt  <= '0;
                            state <= (state == S_H2N_FILL) ? S_H2N_DRAIN : S_N2H_DRAIN;
                        end else if (acc) begin
                            wcnt <= wcnt + CW'(1);
                        end
                    end
                    S_H2N_DRAIN, S_N2H_DRAIN: begin
                        if (last_word) begin
                            wcnt     <= '0;
                            sec_left <= sec_left - 9'd1;
                            if (sec_left == 9'd1)
                                state <= S_DONE;
                            else
                                state <= (state == S_H2N_DRAIN) ? S_H2N_FILL : S_N2H_FILL;
                        end else if (acc) begin
                            wcnt <= wcnt + CW'(1);
                        end
                    end
                    S_DONE: state <= S_IDLE;
                    S_FLUSH: begin
                        // The transfer context is held until the FIFO is empty.
                        if (fifo_empty) begin
                            state     <= S_IDLE;
                            aborted_q <= 1'b1;
                            wcnt      <= '0;
                            sec_left  <= '0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
                if (drop)
                    ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_steed_fifo_seq.sv
module tb_steed_fifo_seq;

    localparam int DW = 16;
    localparam int SW = 32;   // short sectors keep the 256-sector read run small
    localparam int CW = 6;

    localparam int K_WR = 0, K_RD = 1, K_DONE = 2, K_ABT = 3;

    typedef struct {
        int          kind;
        logic [15:0] data;
        logic        hn;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          xfer_start, xfer_dir, xfer_abort;
    logic [7:0]    xfer_sectors;
    logic          host_wr_strb, host_rd_strb, nand_wr_strb, nand_rd_strb;
    logic [DW-1:0] host_data, nand_data;
    logic          fifo_full, fifo_empty;
    logic          fifo_host_nand, fifo_wr_cs, fifo_rd_cs, fifo_wr_en, fifo_rd_en;
    logic [DW-1:0] fifo_data_in;
    logic          host_drq, nand_go, xfer_busy, xfer_done, xfer_aborted, ovf_err;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    steed_fifo_seq #(.DW(DW), .SECTOR_WORDS(SW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .xfer_start(xfer_start), .xfer_dir(xfer_dir), .xfer_sectors(xfer_sectors),
        .xfer_abort(xfer_abort),
        .host_wr_strb(host_wr_strb), .host_rd_strb(host_rd_strb), .host_data(host_data),
        .nand_wr_strb(nand_wr_strb), .nand_rd_strb(nand_rd_strb), .nand_data(nand_data),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_host_nand(fifo_host_nand), .fifo_wr_cs(fifo_wr_cs), .fifo_rd_cs(fifo_rd_cs),
        .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_data_in(fifo_data_in),
        .host_drq(host_drq), .nand_go(nand_go), .xfer_busy(xfer_busy),
        .xfer_done(xfer_done), .xfer_aborted(xfer_aborted), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input logic [15:0] d, input logic hn);
        exp_t e;
        e.kind = k; e.data = d; e.hn = hn;
        sb.push_back(e);
    endtask

    // Monitor: every FIFO transfer or status pulse consumes one expected entry.
    task automatic mon_check(input int k);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected actual_kind=%0d expected=none @%0t", k, $time);
        end else begin
            e = sb.pop_front();
            if (e.kind != k ||
                (k == K_WR && fifo_data_in !== e.data) ||
                ((k == K_WR || k == K_RD) && fifo_host_nand !== e.hn)) begin
                failures++;
                $display("FAIL sb_event actual kind=%0d data=%0h hn=%0b expected kind=%0d data=%0h hn=%0b @%0t",
                         k, fifo_data_in, fifo_host_nand, e.kind, e.data, e.hn, $time);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_wr_en)   mon_check(K_WR);
            if (fifo_rd_en)   mon_check(K_RD);
            if (xfer_done)    mon_check(K_DONE);
            if (xfer_aborted) mon_check(K_ABT);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic dir, input logic [7:0] secs);
        xfer_start = 1'b1; xfer_dir = dir; xfer_sectors = secs;
        cyc();
        xfer_start = 1'b0;
    endtask

    task automatic wr_words(input bit from_host, input int n, input int base);
        for (int i = 0; i < n; i++) begin
            if (from_host) begin
                host_wr_strb = 1'b1; host_data = 16'(base + i);
                push(K_WR, host_data, 1'b1);
            end else begin
                nand_wr_strb = 1'b1; nand_data = 16'(base + i) ^ 16'h5A5A;
                push(K_WR, nand_data, 1'b0);
            end
            cyc();
            host_wr_strb = 1'b0; nand_wr_strb = 1'b0;
        end
    endtask

    task automatic rd_words(input bit by_nand, input int n, input logic hn);
        for (int i = 0; i < n; i++) begin
            if (by_nand) nand_rd_strb = 1'b1; else host_rd_strb = 1'b1;
            push(K_RD, 16'h0, hn);
            cyc();
            nand_rd_strb = 1'b0; host_rd_strb = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        xfer_start = 0; xfer_dir = 0; xfer_sectors = 0; xfer_abort = 0;
        host_wr_strb = 0; host_rd_strb = 0; nand_wr_strb = 0; nand_rd_strb = 0;
        host_data = 16'h1234; nand_data = 16'hBEEF;
        fifo_full = 0; fifo_empty = 1;

        // Reset with strobes and a start toggling.
        for (int i = 0; i < 4; i++) begin
            host_wr_strb = i[0]; nand_wr_strb = ~i[0]; xfer_start = i[1];
            cyc();
            chk("rst_busy", 32'(xfer_busy), 0);
            chk("rst_outs", 32'({fifo_wr_en, fifo_rd_en, fifo_wr_cs, fifo_rd_cs, fifo_host_nand,
                                 host_drq, nand_go, xfer_done, xfer_aborted, ovf_err}), 0);
        end
        host_wr_strb = 0; nand_wr_strb = 0; xfer_start = 0;
        rst_n = 1'b1;
        cyc();
        chk("idle_busy", 32'(xfer_busy), 0);

        // Write command, 2 sectors.
        fifo_empty = 0;
        start(1'b1, 8'd2);
        chk("w_fill_outs", 32'({xfer_busy, host_drq, nand_go, fifo_host_nand, fifo_wr_cs, fifo_rd_cs}),
            32'b110110);
        nand_rd_strb = 1'b1;   // reader strobe during fill is ignored
        cyc();
        nand_rd_strb = 1'b0;
        chk("w_ignored_ovf", 32'(ovf_err), 0);
        wr_words(1, SW, 'h100);
        chk("w_drain_outs", 32'({host_drq, nand_go, fifo_host_nand, fifo_wr_cs, fifo_rd_cs}), 32'b01101);
        rd_words(1, SW, 1'b1);
        chk("w_fill2_drq", 32'({host_drq, nand_go}), 32'b10);
        chk("w_sec_left", 32'(dut.sec_left), 1);
        wr_words(1, SW, 'h200);
        rd_words(1, SW, 1'b1);
        push(K_DONE, 16'h0, 1'b0);
        chk("w_done", 32'(xfer_done), 1);
        cyc();
        chk("w_idle", 32'({xfer_done, xfer_busy}), 0);

        // Overflow: full during H2N fill, then abort with the FIFO empty.
        fifo_full = 1; fifo_empty = 1;
        start(1'b1, 8'd1);
        for (int i = 0; i < 3; i++) begin
            host_wr_strb = 1'b1; cyc(); host_wr_strb = 1'b0;
        end
        chk("ovf_wcnt", 32'(dut.wcnt), 0);
        chk("ovf_err", 32'(ovf_err), 1);
        fifo_full = 0;
        xfer_abort = 1'b1; push(K_ABT, 16'h0, 1'b0);
        cyc();
        xfer_abort = 1'b0;
        chk("ovf_flush", 32'({xfer_busy, fifo_rd_cs, fifo_rd_en}), 32'b110);
        cyc();
        chk("ovf_aborted", 32'({xfer_aborted, xfer_busy}), 32'b10);
        chk("ovf_sticky", 32'(ovf_err), 1);
        cyc();

        // Abort after 20 host words, then flush 20 words.
        fifo_empty = 0;
        start(1'b1, 8'd3);
        chk("abt_ovf_clr", 32'(ovf_err), 0);
        wr_words(1, 20, 'h300);
        chk("abt_wcnt", 32'(dut.wcnt), 20);
        xfer_abort = 1'b1; host_wr_strb = 1'b1;   // abort beats the strobe
        cyc();
        xfer_abort = 1'b0; host_wr_strb = 1'b0;
        chk("abt_flush_outs", 32'({xfer_busy, fifo_host_nand, fifo_rd_cs, fifo_wr_cs, host_drq}),
            32'b11100);
        for (int i = 0; i < 20; i++) begin
            push(K_RD, 16'h0, 1'b1);
            cyc();
        end
        fifo_empty = 1; push(K_ABT, 16'h0, 1'b0);
        cyc();
        chk("abt_done", 32'({xfer_aborted, xfer_busy}), 32'b10);
        cyc();

        // Collision: start and abort together mid-N2H drain.
        fifo_empty = 0;
        start(1'b0, 8'd2);
        wr_words(0, SW, 'h400);
        rd_words(0, 5, 1'b0);
        xfer_start = 1; xfer_dir = 1; xfer_sectors = 8'd5; xfer_abort = 1; host_rd_strb = 1;
        cyc();
        xfer_start = 0; xfer_abort = 0; host_rd_strb = 0;
        push(K_RD, 16'h0, 1'b0);
        chk("col_flush", 32'({xfer_busy, fifo_host_nand, fifo_rd_cs}), 32'b101);
        chk("col_sec_left", 32'(dut.sec_left), 2);
        cyc();
        fifo_empty = 1; push(K_ABT, 16'h0, 1'b0);
        cyc();
        chk("col_aborted", 32'({xfer_aborted, xfer_busy}), 32'b10);
        cyc();

        // Read, sectors = 0 -> 256 sectors.
        fifo_empty = 0;
        start(1'b0, 8'd0);
        chk("rd_sec_left", 32'(dut.sec_left), 256);
        for (int s = 0; s < 256; s++) begin
            wr_words(0, SW, s * SW);
            if (s == 255) chk("rd_last_busy", 32'({xfer_busy, xfer_done}), 32'b10);
            rd_words(0, SW, 1'b0);
        end
        push(K_DONE, 16'h0, 1'b0);
        chk("rd_done", 32'(xfer_done), 1);
        cyc();
        chk("rd_idle", 32'({xfer_busy, xfer_done}), 0);

        repeat (5) cyc();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain actual_pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
